cmp_seq: RTL and testbench

// - Sequential, parametrised magnitude comparator for the calculator datapath.
// - Successor to the single-output combinational less-than compare.
// - Compares two BITS-wide operands MSB-first, DIGIT bits per cycle, with early exit.
// - Returns registered lt/eq/gt flags through a valid/ready handshake.
// - Sits between the operand registers and the ALU result mux.

---
 rtl/cmp_seq.sv | 193 +++++++++++++++++++
 tb/tb_cmp_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq.sv
// -----------------------------------------------------------------------------
// cmp_seq -- sequential magnitude comparator for the calculator datapath
//
// Purpose
//   Compares two BITS-wide operands most-significant digit first, DIGIT bits
//   per clock. It stops at the first digit that differs. Results are returned
//   as registered lt/eq/gt flags through a valid/ready handshake. It replaces
//   the older single-output combinational less-than compare, and sits between
//   the operand registers and the ALU result mux.
//
// Parameters
//   BITS   operand width (>= 1)
//   DIGIT  bits compared per clock (1 <= DIGIT <= BITS, BITS % DIGIT == 0)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands a/b are valid
//   in_ready   out  block is idle and can accept operands
//   a, b       in   operands (BITS wide)
//   is_signed  in   only with CMP_SEQ_SIGNED_EN: treat a/b as two's complement
//   out_valid  out  result flags valid
//   out_ready  in   consumer takes the result
//   a_lt_b     out  A <  B
//   a_eq_b     out  A == B
//   a_gt_b     out  A >  B
//   cycles     out  digits examined for this result (1 .. BITS/DIGIT)
//
// Configuration
//   CMP_SEQ_SIGNED_EN  when defined, adds the is_signed port. A signed
//                      compare flips the MSB of both operands as they are
//                      latched. Unsigned digit compares then order
//                      two's-complement values correctly. Timing is unchanged.
// -----------------------------------------------------------------------------
module cmp_seq #(
   parameter int BITS  = 8,
   parameter int DIGIT = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [BITS-1:0]                   a,
   input  logic [BITS-1:0]                   b,
`ifdef CMP_SEQ_SIGNED_EN
   input  logic                              is_signed,
`endif
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              a_lt_b,
   output logic                              a_eq_b,
   output logic                              a_gt_b,
   output logic [$clog2(BITS/DIGIT+1)-1:0]   cycles
);

   localparam int NDIG  = BITS / DIGIT;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CYC_W = $clog2(NDIG + 1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

   // Elaboration-time parameter sanity checks.
   generate
      if (BITS < 1 || DIGIT < 1 || DIGIT > BITS || (BITS % DIGIT) != 0) begin : g_bad_params
         $error("cmp_seq: illegal BITS/DIGIT combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [BITS-1:0]   a_q, a_d;
   logic [BITS-1:0]   b_q, b_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic              lt_q, lt_d;
   logic              eq_q, eq_d;
   logic              gt_q, gt_d;

   logic              sgn_in;
   logic [DIGIT-1:0]  dig_a, dig_b;

`ifdef CMP_SEQ_SIGNED_EN
   assign sgn_in = is_signed;
`else
   assign sgn_in = 1'b0;
`endif

   // Extract digit i (0 = least significant) of an operand.
   function automatic logic [DIGIT-1:0] digit_of(input logic [BITS-1:0]  v,
                                                 input logic [IDX_W-1:0] i);
      digit_of = v[int'(i) * DIGIT +: DIGIT];
   endfunction

   // Flipping the MSB maps two's complement onto offset binary. Offset binary
   // orders correctly under unsigned comparison. Only the top digit changes,
   // so the early-exit point and the cycle count are the same as unsigned.
   function automatic logic [BITS-1:0] bias_msb(input logic [BITS-1:0] v,
                                                input logic            sgn);
      logic [BITS-1:0] r;
      r            = v;
      r[BITS-1]    = v[BITS-1] ^ sgn;
      bias_msb     = r;
   endfunction

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign a_lt_b    = lt_q;
   assign a_eq_b    = eq_q;
   assign a_gt_b    = gt_q;
   assign cycles    = cyc_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      cyc_d   = cyc_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      dig_a   = digit_of(a_q, idx_q);
      dig_b   = digit_of(b_q, idx_q);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = bias_msb(a, sgn_in);
               b_d     = bias_msb(b, sgn_in);
               idx_d   = IDX_TOP;
               cyc_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            cyc_d = cyc_q + CYC_W'(1);
            if (dig_a != dig_b) begin
               // First differing digit decides the order outright.
               lt_d    = (dig_a < dig_b);
               gt_d    = (dig_a > dig_b);
               eq_d    = 1'b0;
               state_d = DONE;
            end else if (idx_q == '0) begin
               lt_d    = 1'b0;
               gt_d    = 1'b0;
               eq_d    = 1'b1;
               state_d = DONE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end

         DONE: begin
            // Flags and cycles hold until the consumer takes them. New
            // operands are only accepted after the return to IDLE.
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         cyc_q   <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         cyc_q   <= cyc_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
      end
   end

endmodule

// File: tb/tb_cmp_seq.sv
module tb_cmp_seq;

   localparam int NDIG = 4;   // 8-bit operands, 2-bit digits

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       sgn = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       lt, eq, gt;
   logic [2:0] cycles;

   logic        w_in_valid = 1'b0;
   logic        w_in_ready;
   logic [15:0] w_a = '0;
   logic [15:0] w_b = '0;
   logic        w_sgn = 1'b0;
   logic        w_out_valid;
   logic        w_out_ready = 1'b0;
   logic        w_lt, w_eq, w_gt;
   logic [0:0]  w_cycles;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cmp_seq #(.BITS(8), .DIGIT(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
`ifdef CMP_SEQ_SIGNED_EN
      .is_signed (sgn),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_lt_b    (lt),
      .a_eq_b    (eq),
      .a_gt_b    (gt),
      .cycles    (cycles)
   );

   cmp_seq #(.BITS(16), .DIGIT(16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready),
      .a         (w_a),
      .b         (w_b),
`ifdef CMP_SEQ_SIGNED_EN
      .is_signed (w_sgn),
`endif
      .out_valid (w_out_valid),
      .out_ready (w_out_ready),
      .a_lt_b    (w_lt),
      .a_eq_b    (w_eq),
      .a_gt_b    (w_gt),
      .cycles    (w_cycles)
   );

   // Reference: integer comparison of the operand values. The digit count is
   // the position of the highest differing bit, counted in digits from the top.
   function automatic void model(input logic [15:0] va, input logic [15:0] vb,
                                 input int w, input int dg, input bit s,
                                 output logic [2:0] flags, output int cyc);
      longint ia, ib;
      logic [15:0] x;
      int h;
      ia = longint'(va);
      ib = longint'(vb);
      if (s && va[w-1]) ia = ia - (longint'(1) << w);
      if (s && vb[w-1]) ib = ib - (longint'(1) << w);
      flags = {ia < ib, ia == ib, ia > ib};
      x = va ^ vb;
      if (x == '0) begin
         cyc = w / dg;
      end else begin
         h = 0;
         for (int i = 0; i < w; i++) if (x[i]) h = i;
         cyc = w / dg - h / dg;
      end
   endfunction

   // Present operands for one accept edge, then scramble the inputs and wait
   // for out_valid. lat counts clocks from the accept edge.
   task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input bit s,
                         output int lat, output bit ok);
      a = va; b = vb; sgn = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
      lat = 0; ok = 1'b0;
      for (int n = 0; n < 3 * NDIG; n++) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      checks++;
      if ({lt, eq, gt} !== 3'b000 || cycles !== 3'd0) begin
         errors++; $display("FAIL reset_flags: flags=%b cycles=%0d expected 000/0", {lt, eq, gt}, cycles);
      end
      checks++;
      if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || {w_lt, w_eq, w_gt} !== 3'b000 || w_cycles !== 1'b0) begin
         errors++; $display("FAIL reset_wide: rdy=%b vld=%b flags=%b cyc=%0d", w_in_ready, w_out_valid, {w_lt, w_eq, w_gt}, w_cycles);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_gt_early();
      int lat; bit ok;
      run_op(8'hC0, 8'h40, 1'b0, lat, ok);
      checks++;
      if (!ok || lat != 1) begin
         errors++; $display("FAIL gt_latency: ok=%b lat=%0d expected 1", ok, lat);
      end
      checks++;
      if ({lt, eq, gt} !== 3'b001 || cycles !== 3'd1) begin
         errors++; $display("FAIL gt_result: flags=%b cycles=%0d expected 001/1", {lt, eq, gt}, cycles);
      end
      release_result();
   endtask

   task automatic test_eq_hold();
      int lat; bit ok; bit held;
      run_op(8'h5A, 8'h5A, 1'b0, lat, ok);
      checks++;
      if (!ok || lat != 4 || {lt, eq, gt} !== 3'b010 || cycles !== 3'd4) begin
         errors++; $display("FAIL eq_result: ok=%b lat=%0d flags=%b cycles=%0d expected 4/010/4", ok, lat, {lt, eq, gt}, cycles);
      end
      held = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || {lt, eq, gt} !== 3'b010 || cycles !== 3'd4) held = 1'b0;
      end
      checks++;
      if (!held) begin
         errors++; $display("FAIL eq_hold: vld=%b flags=%b cycles=%0d expected 1/010/4", out_valid, {lt, eq, gt}, cycles);
      end
      out_ready = 1'b1; in_valid = 1'b1; a = 8'h00; b = 8'hFF;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL eq_release: vld=%b rdy=%b expected 0/1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL no_back_to_back: in_ready=%b expected 1 (no accept)", in_ready);
      end
   endtask

   task automatic test_lt_abort();
      int lat; bit ok; bit quiet;
      run_op(8'h12, 8'h13, 1'b0, lat, ok);
      checks++;
      if (!ok || lat != 4 || {lt, eq, gt} !== 3'b100 || cycles !== 3'd4) begin
         errors++; $display("FAIL lt_result: ok=%b lat=%0d flags=%b cycles=%0d expected 4/100/4", ok, lat, {lt, eq, gt}, cycles);
      end
      release_result();
      a = 8'h33; b = 8'h33; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL abort_busy: rdy=%b vld=%b expected 0/0", in_ready, out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || {lt, eq, gt} !== 3'b000 || cycles !== 3'd0) begin
         errors++; $display("FAIL abort_reset: rdy=%b vld=%b flags=%b cycles=%0d expected 1/0/000/0", in_ready, out_valid, {lt, eq, gt}, cycles);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
      end
      checks++;
      if (!quiet) begin
         errors++; $display("FAIL abort_lost: vld=%b rdy=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_random();
      int lat; bit ok; logic [2:0] ef; int ec; logic [7:0] va, vb; bit s; bit held;
      for (int t = 0; t < 40; t++) begin
         va = 8'($urandom);
         case ($urandom_range(0, 2))
            0: vb = 8'($urandom);
            1: vb = va;
            default: vb = va ^ (8'h01 << $urandom_range(0, 7));
         endcase
`ifdef CMP_SEQ_SIGNED_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         model({8'h00, va}, {8'h00, vb}, 8, 2, s, ef, ec);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rand_ready[%0d]: in_ready=%b expected 1", t, in_ready);
         end
         run_op(va, vb, s, lat, ok);
         checks++;
         if (!ok || lat != ec || {lt, eq, gt} !== ef || int'(cycles) != ec) begin
            errors++; $display("FAIL rand_op[%0d] a=%h b=%h s=%b: ok=%b lat=%0d flags=%b cycles=%0d expected lat=%0d flags=%b cycles=%0d",
                               t, va, vb, s, ok, lat, {lt, eq, gt}, cycles, ec, ef, ec);
         end
         held = 1'b1;
         for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || {lt, eq, gt} !== ef) held = 1'b0;
         end
         checks++;
         if (!held) begin
            errors++; $display("FAIL rand_hold[%0d]: vld=%b flags=%b expected 1/%b", t, out_valid, {lt, eq, gt}, ef);
         end
         release_result();
      end
   endtask

   task automatic test_signed();
`ifdef CMP_SEQ_SIGNED_EN
      int lat; bit ok;
      run_op(8'hFF, 8'h01, 1'b1, lat, ok);
      checks++;
      if (!ok || {lt, eq, gt} !== 3'b100 || cycles !== 3'd1) begin
         errors++; $display("FAIL signed_lt: ok=%b flags=%b cycles=%0d expected 100/1", ok, {lt, eq, gt}, cycles);
      end
      release_result();
      run_op(8'hFF, 8'h01, 1'b0, lat, ok);
      checks++;
      if (!ok || {lt, eq, gt} !== 3'b001 || cycles !== 3'd1) begin
         errors++; $display("FAIL unsigned_gt: ok=%b flags=%b cycles=%0d expected 001/1", ok, {lt, eq, gt}, cycles);
      end
      release_result();
`endif
   endtask

   task automatic test_wide();
      logic [2:0] ef; int ec; int lat; bit ok;
      logic [15:0] va, vb; bit s;
      for (int t = 0; t < 6; t++) begin
         if (t == 0) begin va = 16'h8000; vb = 16'h7FFF; end
         else if (t == 1) begin va = 16'hBEEF; vb = 16'hBEEF; end
         else begin va = 16'($urandom); vb = 16'($urandom); end
`ifdef CMP_SEQ_SIGNED_EN
         s = (t < 2) ? 1'b0 : 1'($urandom);
`else
         s = 1'b0;
`endif
         model(va, vb, 16, 16, s, ef, ec);
         w_a = va; w_b = vb; w_sgn = s; w_in_valid = 1'b1;
         @(posedge clk); #1;
         w_in_valid = 1'b0; w_a = 16'($urandom); w_b = 16'($urandom);
         lat = 0; ok = 1'b0;
         for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            lat++;
            if (w_out_valid) begin ok = 1'b1; break; end
         end
         checks++;
         if (!ok || lat != ec || {w_lt, w_eq, w_gt} !== ef || int'(w_cycles) != ec) begin
            errors++; $display("FAIL wide_op[%0d] a=%h b=%h: ok=%b lat=%0d flags=%b cycles=%0d expected lat=%0d flags=%b cycles=%0d",
                               t, va, vb, ok, lat, {w_lt, w_eq, w_gt}, w_cycles, ec, ef, ec);
         end
         w_out_ready = 1'b1;
         @(posedge clk); #1;
         w_out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_gt_early();
      test_eq_hold();
      test_lt_abort();
      test_signed();
      test_random();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
